// File: rtl/pipeline_control.sv
// Pipeline latch sequencer: per-latch update/flush, PC enable, halt drain FSM
// and a saturating stall-cycle counter.
module pipeline_control #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             idex_mem_to_reg,
  input  logic [REG_W-1:0] idex_wr_addr,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_update,
  output logic             ifid_flush,
  output logic             idex_update,
  output logic             idex_flush,
  output logic             exmem_update,
  output logic             exmem_flush,
  output logic             memwb_update,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             halt_r;
  logic [CNT_W-1:0] stall_count_r;
  logic             dstall_s;
  logic             lduse_s;

  assign dstall_s = mem_dreq & ~dhit;
  assign lduse_s  = idex_mem_to_reg & (idex_wr_addr != {REG_W{1'b0}}) &
                    ((idex_wr_addr == id_rs) | (idex_wr_addr == id_rt));

  // State, sticky halt and stall counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r       <= RUN;
      halt_r        <= 1'b0;
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      halt_r  <= halt_r | ((state_r == DRAIN) & wb_halt);
      if ((state_r == RUN) && !pc_en && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  // Next-state and latch control decode; flush never coexists with update.
  always_comb begin
    state_next_s = state_r;
    pc_en        = 1'b0;
    ifid_update  = 1'b0;
    ifid_flush   = 1'b0;
    idex_update  = 1'b0;
    idex_flush   = 1'b0;
    exmem_update = 1'b0;
    exmem_flush  = 1'b0;
    memwb_update = 1'b0;
    memwb_flush  = 1'b0;
    case (state_r)
      RUN: begin
        if (dstall_s) begin
          // Bubble into WB so the stalled MEM instruction is not committed twice.
          memwb_flush = 1'b1;
        end else if (mem_halt) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          memwb_update = 1'b1;
          state_next_s = DRAIN;
        end else if (mem_redirect) begin
          pc_en        = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          memwb_update = 1'b1;
        end else if (lduse_s) begin
          idex_flush   = 1'b1;
          exmem_update = 1'b1;
          memwb_update = 1'b1;
        end else if (!ihit) begin
          ifid_flush   = 1'b1;
          idex_update  = 1'b1;
          exmem_update = 1'b1;
          memwb_update = 1'b1;
        end else begin
          pc_en        = 1'b1;
          ifid_update  = 1'b1;
          idex_update  = 1'b1;
          exmem_update = 1'b1;
          memwb_update = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_flush  = 1'b1;
        memwb_update = ~wb_halt;
        if (wb_halt) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = DRAIN;
        end
      end
      HALTED: begin
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  assign halt        = halt_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_pipeline_control;

  logic        CLK, nRST;
  logic        ihit, dhit, mem_dreq, idex_mem_to_reg, mem_redirect, mem_halt, wb_halt;
  logic [4:0]  id_rs, id_rt, idex_wr_addr;
  logic        pc_en, ifid_update, ifid_flush, idex_update, idex_flush;
  logic        exmem_update, exmem_flush, memwb_update, memwb_flush, halt;
  logic [15:0] stall_count;

  pipeline_control #(.CNT_W(16), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .id_rs(id_rs), .id_rt(id_rt), .idex_mem_to_reg(idex_mem_to_reg),
    .idex_wr_addr(idex_wr_addr), .mem_redirect(mem_redirect),
    .mem_halt(mem_halt), .wb_halt(wb_halt), .pc_en(pc_en),
    .ifid_update(ifid_update), .ifid_flush(ifid_flush),
    .idex_update(idex_update), .idex_flush(idex_flush),
    .exmem_update(exmem_update), .exmem_flush(exmem_flush),
    .memwb_update(memwb_update), .memwb_flush(memwb_flush),
    .halt(halt), .stall_count(stall_count)
  );

  // Control order: {pc_en, ifid u/f, idex u/f, exmem u/f, memwb u/f}
  localparam logic [8:0] ALL_UPD = 9'b1_10_10_10_10;
  localparam logic [8:0] DSTALL  = 9'b0_00_00_00_01;
  localparam logic [8:0] REDIR   = 9'b1_01_01_01_10;
  localparam logic [8:0] LDUSE   = 9'b0_00_01_10_10;
  localparam logic [8:0] IMISS   = 9'b0_01_10_10_10;
  localparam logic [8:0] HALTGO  = 9'b0_01_01_01_10;
  localparam logic [8:0] DRAIN_L = 9'b0_01_01_01_00;
  localparam logic [8:0] NONE    = 9'b0_00_00_00_00;

  typedef struct {
    string       tag;
    logic [8:0]  ctrl;
    logic        hlt;
    logic [15:0] cnt;
    bit          chk;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) begin
        cmp({e.tag, ".ctrl"}, {23'd0, pc_en, ifid_update, ifid_flush, idex_update, idex_flush,
             exmem_update, exmem_flush, memwb_update, memwb_flush}, {23'd0, e.ctrl});
        cmp({e.tag, ".halt"}, {31'd0, halt}, {31'd0, e.hlt});
        cmp({e.tag, ".stall_count"}, {16'd0, stall_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic set_in(input logic ih, input logic dh, input logic dreq,
                        input logic [4:0] rs, input logic [4:0] rt, input logic mtr,
                        input logic [4:0] wr, input logic rdr, input logic mh, input logic wh);
    ihit = ih; dhit = dh; mem_dreq = dreq; id_rs = rs; id_rt = rt;
    idex_mem_to_reg = mtr; idex_wr_addr = wr; mem_redirect = rdr;
    mem_halt = mh; wb_halt = wh;
  endtask

  task automatic step(input string tag, input logic [8:0] c, input logic h,
                      input logic [15:0] n, input bit chk);
    exp_t e;
    e.tag = tag; e.ctrl = c; e.hlt = h; e.cnt = n; e.chk = chk;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    step("reset", ALL_UPD, 1'b0, 16'd0, 1'b1);
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) step("run", ALL_UPD, 1'b0, 16'd0, 1'b1);

    set_in(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("dstall", DSTALL, 1'b0, 16'(i), 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("dhit", ALL_UPD, 1'b0, 16'd3, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("after_dstall", ALL_UPD, 1'b0, 16'd3, 1'b1);

    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    step("lduse_rt", LDUSE, 1'b0, 16'd3, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lduse_r0", ALL_UPD, 1'b0, 16'd4, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step("lduse_rs", LDUSE, 1'b0, 16'd4, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    step("no_load", ALL_UPD, 1'b0, 16'd5, 1'b1);

    set_in(1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    step("redirect", REDIR, 1'b0, 16'd5, 1'b1);
    set_in(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("redir_dstall", DSTALL, 1'b0, 16'd5, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("imiss", IMISS, 1'b0, 16'd6, 1'b1);

    set_in(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("halt_dstall", DSTALL, 1'b0, 16'd7, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("halt_go", HALTGO, 1'b0, 16'd8, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("drain", HALTGO, 1'b0, 16'd9, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("drain_wb", DRAIN_L, 1'b0, 16'd9, 1'b1);
    for (int i = 0; i < 20; i++) begin
      set_in(i[0], 1'b0, i[1], 5'd1, 5'd1, 1'b1, 5'd1, i[2], 1'b1, 1'b0);
      step("halted", NONE, 1'b1, 16'd9, 1'b1);
    end

    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    cmp("async_rst.halt", {31'd0, halt}, 32'd0);
    cmp("async_rst.stall_count", {16'd0, stall_count}, 32'd0);
    cmp("async_rst.pc_en", {31'd0, pc_en}, 32'd1);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65541; i++) begin
      step("saturate", IMISS, 1'b0, (i < 65535) ? 16'(i) : 16'hFFFF,
           (i < 3) || (i >= 65530));
    end
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("post_sat", ALL_UPD, 1'b0, 16'hFFFF, 1'b1);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge CLK);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue actual=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
